// File: rtl/int_fp_conv.sv
// INT16 <-> FP16 converter, 3-stage valid/ready pipeline (unpack+LZC, shift, round+pack); 3-cycle latency, 1 word/cycle.
// Stalls propagate back stage by stage and bubbles collapse; define INT_FP_CONV_RNE_EN for round-to-nearest-even, else truncate.
module int_fp_conv (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_flags
);

    logic        s1_vld, s2_vld, s3_vld;
    logic        rdy1, rdy2, rdy3;

    assign rdy3      = !s3_vld || out_ready;
    assign rdy2      = !s2_vld || rdy3;
    assign rdy1      = !s1_vld || rdy2;
    assign in_ready  = rdy1 && !rst;
    assign out_valid = s3_vld;

    // S1: unpack. Both directions reduce to a significand plus a shift count.
    logic [15:0] i_mag;
    logic [4:0]  i_lz;
    logic [15:0] u_a;
    logic [4:0]  u_sh;
    logic        u_nan, u_inf, u_zero;

    always_comb begin
        i_mag = in_data[15] ? (~in_data + 16'd1) : in_data;
        i_lz  = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (i_mag[i]) i_lz = 5'(15 - i);
        end
        u_a    = i_mag;
        u_sh   = i_lz;
        u_nan  = 1'b0;
        u_inf  = 1'b0;
        u_zero = (in_data == 16'd0);
        if (mode) begin
            u_a    = {5'd0, in_data[14:10] != 5'd0, in_data[9:0]};
            u_sh   = (in_data[14:10] == 5'd0) ? 5'd1 : in_data[14:10];
            u_nan  = (in_data[14:10] == 5'd31) && (in_data[9:0] != 10'd0);
            u_inf  = (in_data[14:10] == 5'd31) && (in_data[9:0] == 10'd0);
            u_zero = 1'b0;
        end
    end

    logic        s1_mode, s1_sign, s1_nan, s1_inf, s1_zero;
    logic [15:0] s1_a;
    logic [4:0]  s1_sh;

    // S2: decode places the binary point at bit 26 of a wide left shift; encode normalises the magnitude.
    logic [41:0] d_wide;
    logic [15:0] e_norm;
    logic [15:0] n_int;
    logic        n_rnd, n_stk;
    logic [4:0]  n_exp;

    assign d_wide = {26'd0, s1_a} << ({1'b0, s1_sh} + 6'd1);
    assign e_norm = s1_a << s1_sh;

    always_comb begin
        n_int = {5'd0, e_norm[15:5]};
        n_rnd = e_norm[4];
        n_stk = |e_norm[3:0];
        n_exp = 5'd30 - s1_sh;
        if (s1_mode) begin
            n_int = d_wide[41:26];
            n_rnd = d_wide[25];
            n_stk = |d_wide[24:0];
            n_exp = 5'd0;
        end
    end

    logic        s2_mode, s2_sign, s2_nan, s2_inf, s2_zero, s2_rnd, s2_stk;
    logic [15:0] s2_int;
    logic [4:0]  s2_exp;

    // S3: round, saturate / renormalise, pack.
    logic        r_inc, r_inx;
    logic [16:0] r_sum;
    logic [4:0]  r_exp;
    logic [15:0] r_data;
    logic [2:0]  r_flags;

`ifdef INT_FP_CONV_RNE_EN
    assign r_inc = s2_rnd && (s2_stk || s2_int[0]);
`else
    assign r_inc = 1'b0;
`endif
    assign r_inx = s2_rnd || s2_stk;
    assign r_sum = {1'b0, s2_int} + {16'd0, r_inc};
    assign r_exp = s2_exp + {4'd0, r_sum[11]};

    always_comb begin
        r_data  = 16'd0;
        r_flags = 3'b000;
        if (s2_mode) begin
            if (s2_nan) begin
                r_flags = 3'b100;
            end else if (s2_inf) begin
                r_data  = s2_sign ? 16'h8000 : 16'h7FFF;
                r_flags = 3'b010;
            end else if (r_sum > (s2_sign ? 17'd32768 : 17'd32767)) begin
                r_data  = s2_sign ? 16'h8000 : 16'h7FFF;
                r_flags = {2'b01, r_inx};
            end else begin
                r_data  = s2_sign ? (16'd0 - r_sum[15:0]) : r_sum[15:0];
                r_flags = {2'b00, r_inx};
            end
        end else if (!s2_zero) begin
            r_data  = {s2_sign, r_exp, r_sum[9:0]};
            r_flags = {2'b00, r_inx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            s3_vld    <= 1'b0;
            out_data  <= 16'd0;
            out_flags <= 3'b000;
        end else begin
            if (rdy1) s1_vld <= in_valid;
            if (rdy2) s2_vld <= s1_vld;
            if (rdy3) s3_vld <= s2_vld;
            if (rdy3 && s2_vld) begin
                out_data  <= r_data;
                out_flags <= r_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy1 && in_valid) begin
            s1_mode <= mode;
            s1_sign <= in_data[15];
            s1_a    <= u_a;
            s1_sh   <= u_sh;
            s1_nan  <= u_nan;
            s1_inf  <= u_inf;
            s1_zero <= u_zero;
        end
        if (rdy2 && s1_vld) begin
            s2_mode <= s1_mode;
            s2_sign <= s1_sign;
            s2_nan  <= s1_nan;
            s2_inf  <= s1_inf;
            s2_zero <= s1_zero;
            s2_int  <= n_int;
            s2_rnd  <= n_rnd;
            s2_stk  <= n_stk;
            s2_exp  <= n_exp;
        end
    end

endmodule

// File: tb/tb_int_fp_conv.sv
// Randomised and directed bench for int_fp_conv against a real-arithmetic reference model.
module tb_int_fp_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  out_flags;

    int_fp_conv dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [18:0] exp_q[$];
    int          cyc_q[$];
    logic        strict = 1'b0;
    logic        acc = 1'b0;
    logic        prev_stall = 1'b0;
    logic [18:0] prev_out = 19'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, want);
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else repeat (-n) r = r / 2.0;
        return r;
    endfunction

    // Returns {invalid, overflow, inexact, data}.
    function automatic logic [18:0] ref_conv(input logic md, input logic [15:0] x);
        real     v, fr;
        longint  ip;
        int      p, mg;
        logic    inx;
        if (md) begin
            if (x[14:10] == 5'd31)
                return (x[9:0] != 10'd0) ? {3'b100, 16'h0000} : {3'b010, x[15] ? 16'h8000 : 16'h7FFF};
            if (x[14:10] == 5'd0) v = real'(int'(x[9:0])) * pow2(-24);
            else v = real'(1024 + int'(x[9:0])) * pow2(int'(x[14:10]) - 25);
            ip = longint'($rtoi(v));
            fr = v - real'(ip);
`ifdef INT_FP_CONV_RNE_EN
            if (fr > 0.5 || (fr == 0.5 && ip % 2 == 1)) ip++;
`endif
            inx = (fr != 0.0);
            if (ip > (x[15] ? 32768 : 32767))
                return {2'b01, inx, x[15] ? 16'h8000 : 16'h7FFF};
            return {2'b00, inx, x[15] ? 16'(-ip) : 16'(ip)};
        end else begin
            if (x == 16'd0) return 19'd0;
            mg = x[15] ? 65536 - int'(x) : int'(x);
            p = 0;
            while ((2 << p) <= mg) p++;
            v  = real'(mg) * pow2(10 - p);
            ip = longint'($rtoi(v));
            fr = v - real'(ip);
`ifdef INT_FP_CONV_RNE_EN
            if (fr > 0.5 || (fr == 0.5 && ip % 2 == 1)) ip++;
`endif
            inx = (fr != 0.0);
            if (ip == 2048) begin
                ip = 1024;
                p++;
            end
            return {2'b00, inx, x[15], 5'(15 + p), 10'(ip - 1024)};
        end
    endfunction

    // One clock: drive at negedge, evaluate the handshake the coming posedge will perform.
    task automatic cycle(input logic r, input logic iv, input logic md, input logic [15:0] d,
                         input logic ordy, input logic [18:0] want);
        logic [18:0] w;
        int          c;
        @(negedge clk);
        rst = r; in_valid = iv; mode = md; in_data = d; out_ready = ordy;
        #1;
        cyc++;
        acc = 1'b0;
        if (r) begin
            exp_q.delete();
            cyc_q.delete();
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            chk("hold_vld", 32'(out_valid), 32'd1);
            chk("hold_dat", 32'({out_flags, out_data}), 32'(prev_out));
        end
        chk("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 3 && !ordy)));
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                w = exp_q.pop_front();
                c = cyc_q.pop_front();
                chk("result", 32'({out_flags, out_data}), 32'(w));
                if (strict) chk("latency", 32'(cyc - c), 32'd3);
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            exp_q.push_back(want);
            cyc_q.push_back(cyc);
        end
        prev_stall = out_valid && !ordy;
        prev_out   = {out_flags, out_data};
    endtask

    task automatic rst_state_chk();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) cycle(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 19'd0);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic        md;
        logic [15:0] x;
        logic [18:0] want;
    } vec_t;

    vec_t tab[$];

    initial begin
`ifdef INT_FP_CONV_RNE_EN
        tab.push_back('{1'b1, 16'h3E00, {3'b001, 16'h0002}});
        tab.push_back('{1'b1, 16'h3A00, {3'b001, 16'h0001}});
        tab.push_back('{1'b1, 16'hBE00, {3'b001, 16'hFFFE}});
        tab.push_back('{1'b0, 16'h7FFF, {3'b001, 16'h7800}});
        tab.push_back('{1'b0, 16'h0803, {3'b001, 16'h6802}});
`else
        tab.push_back('{1'b1, 16'h3E00, {3'b001, 16'h0001}});
        tab.push_back('{1'b1, 16'h3A00, {3'b001, 16'h0000}});
        tab.push_back('{1'b1, 16'hBE00, {3'b001, 16'hFFFF}});
        tab.push_back('{1'b0, 16'h7FFF, {3'b001, 16'h77FF}});
        tab.push_back('{1'b0, 16'h0803, {3'b001, 16'h6801}});
`endif
        tab.push_back('{1'b1, 16'h3C00, {3'b000, 16'h0001}});
        tab.push_back('{1'b0, 16'h8000, {3'b000, 16'hF800}});
        tab.push_back('{1'b1, 16'h4100, {3'b001, 16'h0002}});
        tab.push_back('{1'b0, 16'h0001, {3'b000, 16'h3C00}});
        tab.push_back('{1'b1, 16'h7C00, {3'b010, 16'h7FFF}});
        tab.push_back('{1'b0, 16'hFFFF, {3'b000, 16'hBC00}});
        tab.push_back('{1'b1, 16'h7E00, {3'b100, 16'h0000}});
        tab.push_back('{1'b0, 16'h0000, {3'b000, 16'h0000}});
        tab.push_back('{1'b1, 16'hF800, {3'b000, 16'h8000}});
        tab.push_back('{1'b0, 16'h0801, {3'b001, 16'h6800}});
        tab.push_back('{1'b1, 16'h8000, {3'b000, 16'h0000}});
        tab.push_back('{1'b1, 16'h0001, {3'b001, 16'h0000}});
        tab.push_back('{1'b1, 16'h3800, {3'b001, 16'h0000}});
        tab.push_back('{1'b1, 16'hFC00, {3'b010, 16'h8000}});
        tab.push_back('{1'b1, 16'h7800, {3'b010, 16'h7FFF}});
        tab.push_back('{1'b1, 16'h7BFF, {3'b010, 16'h7FFF}});

        // Reset with in_valid asserted: nothing may be captured.
        cycle(1'b1, 1'b1, 1'b1, 16'h3C00, 1'b1, 19'd0);
        cycle(1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 19'd0);
        rst_state_chk();

        // Directed corner cases, back to back with mixed modes, out_ready held high.
        strict = 1'b1;
        foreach (tab[i]) cycle(1'b0, 1'b1, tab[i].md, tab[i].x, 1'b1, tab[i].want);
        drain();
        strict = 1'b0;

        // Random stream; the first 8 words alternate mode.
        begin
            int          sent = 0;
            logic        pv = 1'b0;
            logic        pm = 1'b0;
            logic [15:0] pd = 16'd0;
            for (int k = 0; k < 2000 && sent < 300; k++) begin
                if (!pv && $urandom_range(0, 9) < 8) begin
                    pv = 1'b1;
                    pm = (sent < 8) ? sent[0] : 1'($urandom_range(0, 1));
                    pd = 16'($urandom);
                end
                cycle(1'b0, pv, pm, pd, $urandom_range(0, 9) < 6, ref_conv(pm, pd));
                if (acc) begin
                    pv = 1'b0;
                    sent++;
                end
            end
            chk("random_sent", 32'(sent), 32'd300);
            drain();
        end

        // Mid-stream reset: three stalled words must vanish.
        cycle(1'b0, 1'b1, 1'b1, 16'h3C00, 1'b0, {3'b000, 16'h0001});
        cycle(1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, {3'b000, 16'h3C00});
        cycle(1'b0, 1'b1, 1'b1, 16'h4100, 1'b0, {3'b001, 16'h0002});
        chk("preload_cnt", 32'(exp_q.size()), 32'd3);
        cycle(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 19'd0);
        rst_state_chk();
        strict = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, {3'b000, 16'hBC00});
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 19'd0);
        chk("post_rst_done", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
